// File: rtl/op_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : op_scheduler_pkg
// Brief    : Packet constants, FSM state encoding and packet builder shared
//            by the op_scheduler slice.
// Revision : 1.0 - initial release
// ============================================================================
package op_scheduler_pkg;

    localparam int          c_payload_w = 16;
    localparam int          c_pkt_w     = 40;

    localparam logic [7:0]  c_hdr       = 8'hC6;
    localparam logic [7:0]  c_kbd_id    = 8'h10;
    localparam logic [7:0]  c_mouse_id  = 8'h01;
    localparam logic [39:0] c_pwr_pkt   = 40'hC6_71_00_00_00;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } state_t;

    function automatic logic [c_pkt_w-1:0] make_pkt(input logic [7:0]             id,
                                                    input logic [c_payload_w-1:0] payload);
        return {c_hdr, id, 8'h00, payload};
    endfunction

endpackage
`default_nettype wire

// File: rtl/op_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : op_scheduler_if
// Brief    : Source handshakes, power-on request and transmitter port bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface op_scheduler_if;
    import op_scheduler_pkg::*;

    logic                   power_on_req;
    logic                   kbd_valid;
    logic                   kbd_ready;
    logic [c_payload_w-1:0] kbd_data;
    logic                   mouse_valid;
    logic                   mouse_ready;
    logic [c_payload_w-1:0] mouse_data;
    logic [c_pkt_w-1:0]     tx_data;
    logic                   tx_valid;
    logic                   tx_ready;
    logic                   tx_done;
    logic                   busy;

    modport master (
        output power_on_req, kbd_valid, kbd_data, mouse_valid, mouse_data,
               tx_ready, tx_done,
        input  kbd_ready, mouse_ready, tx_data, tx_valid, busy
    );

    modport slave (
        input  power_on_req, kbd_valid, kbd_data, mouse_valid, mouse_data,
               tx_ready, tx_done,
        output kbd_ready, mouse_ready, tx_data, tx_valid, busy
    );

endinterface
`default_nettype wire

// File: rtl/op_src_buffer.sv
`default_nettype none
// ============================================================================
// Module   : op_src_buffer
// Brief    : One-entry valid/ready holding register with clear input.
// Revision : 1.0 - initial release
// ============================================================================
module op_src_buffer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_clear,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;

    // Clear only ever hits a full buffer, when ready is low, so it cannot
    // collide with a capture in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_valid && !r_full) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end
    end

    assign o_ready = !r_full;
    assign o_full  = r_full;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/op_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : op_scheduler
// Brief    : Arbitrates power-on, keyboard and mouse packets onto one serial
//            transmitter with an enforced idle gap after each packet.
//            Define OP_SCHED_RR_EN for keyboard/mouse round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module op_scheduler
    import op_scheduler_pkg::*;
#(
    parameter int GAP_CYCLES = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    op_scheduler_if.slave bus
);

    localparam int                 c_cnt_w    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_gap_load = c_cnt_w'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_pkt_w-1:0]     r_tx_data;
    logic [c_pkt_w-1:0]     w_tx_data_nxt;
    logic [c_cnt_w-1:0]     r_gap_cnt;
    logic [c_cnt_w-1:0]     w_gap_cnt_nxt;
    logic                   r_pwr_pend;
    logic                   w_grant_pwr;
    logic                   w_kbd_clr;
    logic                   w_mouse_clr;
    logic                   w_pick_mouse;
    logic                   w_kbd_full;
    logic                   w_mouse_full;
    logic [c_payload_w-1:0] w_kbd_data;
    logic [c_payload_w-1:0] w_mouse_data;

    op_src_buffer #(.WIDTH(c_payload_w)) u_kbd_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .i_valid (bus.kbd_valid),
        .o_ready (bus.kbd_ready),
        .i_data  (bus.kbd_data),
        .i_clear (w_kbd_clr),
        .o_full  (w_kbd_full),
        .o_data  (w_kbd_data)
    );

    op_src_buffer #(.WIDTH(c_payload_w)) u_mouse_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .i_valid (bus.mouse_valid),
        .o_ready (bus.mouse_ready),
        .i_data  (bus.mouse_data),
        .i_clear (w_mouse_clr),
        .o_full  (w_mouse_full),
        .o_data  (w_mouse_data)
    );

`ifdef OP_SCHED_RR_EN
    logic r_rr_ptr;  // 0: keyboard wins the next tie, 1: mouse

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rr_ptr <= 1'b0;
        end else if (w_kbd_clr || w_mouse_clr) begin
            r_rr_ptr <= ~r_rr_ptr;
        end
    end

    assign w_pick_mouse = w_mouse_full && (!w_kbd_full || r_rr_ptr);
`else
    assign w_pick_mouse = w_mouse_full && !w_kbd_full;
`endif

    // A pulse arriving in the grant cycle opens a fresh request.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pwr_pend <= 1'b0;
        end else begin
            r_pwr_pend <= (r_pwr_pend && !w_grant_pwr) || bus.power_on_req;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_tx_data <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_tx_data <= w_tx_data_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_tx_data_nxt = r_tx_data;
        w_gap_cnt_nxt = r_gap_cnt;
        w_grant_pwr   = 1'b0;
        w_kbd_clr     = 1'b0;
        w_mouse_clr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pwr_pend) begin
                    w_tx_data_nxt = c_pwr_pkt;
                    w_grant_pwr   = 1'b1;
                    w_state_nxt   = ST_SEND;
                end else if (w_kbd_full || w_mouse_full) begin
                    if (w_pick_mouse) begin
                        w_tx_data_nxt = make_pkt(c_mouse_id, w_mouse_data);
                        w_mouse_clr   = 1'b1;
                    end else begin
                        w_tx_data_nxt = make_pkt(c_kbd_id, w_kbd_data);
                        w_kbd_clr     = 1'b1;
                    end
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (bus.tx_ready) begin
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.tx_done) begin
                    if (GAP_CYCLES == 0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt   = ST_GAP;
                        w_gap_cnt_nxt = c_gap_load;
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - c_cnt_w'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.tx_data  = r_tx_data;
    assign bus.tx_valid = (r_state == ST_SEND);
    assign bus.busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_op_scheduler
// Brief    : Self-checking bench for op_scheduler (default gap and zero gap).
// Revision : 1.0 - initial release
// ============================================================================
module tb_op_scheduler;

    localparam int c_gap_a = 16;
    localparam int c_gap_z = 0;

    typedef struct packed {
        logic        pwr;
        logic        kf;
        logic [15:0] kd;
        logic        mf;
        logic [15:0] md;
        logic        ptr;
        logic        offer;
        logic        await_d;
        logic [7:0]  hold;
        logic [39:0] pkt;
    } mdl_t;

    logic clk = 1'b0;
    logic reset_n;

    op_scheduler_if bus_a ();
    op_scheduler_if bus_z ();

    op_scheduler u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    op_scheduler #(.GAP_CYCLES(c_gap_z)) u_dut_z (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_z)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    int          done_mode = 0;   // 0 manual, 1 immediate, 2 random
    logic        s_rst_n = 1'b0, s_pwr = 1'b0, s_kv = 1'b0, s_mv = 1'b0;
    logic        s_rdy = 1'b0, s_done = 1'b0;
    logic [15:0] s_kd = '0, s_md = '0;
    mdl_t        m0 = '0, m1 = '0;
    logic [39:0] log_d[$];
    int          log_c[$];

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    // Packet-level model: what must be offered, owed and blocked after one edge.
    function automatic mdl_t mdl_step(input mdl_t m, input int gap,
                                      input logic pwr, input logic kv, input logic [15:0] kd,
                                      input logic mv, input logic [15:0] md,
                                      input logic rdy, input logic done);
        mdl_t n = m;
        logic free = !m.offer && !m.await_d && (m.hold == 0);
        logic gp = 1'b0, gk = 1'b0, gm = 1'b0;
        if (free) begin
            if (m.pwr) gp = 1'b1;
            else if (m.kf && m.mf) begin
`ifdef OP_SCHED_RR_EN
                if (m.ptr) gm = 1'b1; else gk = 1'b1;
`else
                gk = 1'b1;
`endif
            end
            else if (m.kf) gk = 1'b1;
            else if (m.mf) gm = 1'b1;
        end
        if (gp) begin n.offer = 1'b1; n.pkt = 40'hC671000000; end
        if (gk) begin n.offer = 1'b1; n.pkt = {24'hC61000, m.kd}; end
        if (gm) begin n.offer = 1'b1; n.pkt = {24'hC60100, m.md}; end
        if (gk || gm) n.ptr = !m.ptr;
        n.pwr = (m.pwr && !gp) || pwr;
        if (gk) n.kf = 1'b0;
        else if (kv && !m.kf) begin n.kf = 1'b1; n.kd = kd; end
        if (gm) n.mf = 1'b0;
        else if (mv && !m.mf) begin n.mf = 1'b1; n.md = md; end
        if (m.offer && rdy) begin n.offer = 1'b0; n.await_d = 1'b1; end
        if (m.await_d && done) begin n.await_d = 1'b0; n.hold = 8'(gap); end
        else if (m.hold > 0) n.hold = m.hold - 8'd1;
        return n;
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
        cmp("a_tx_valid",    bus_a.tx_valid,    m0.offer);
        cmp("a_tx_data",     bus_a.tx_data,     m0.pkt);
        cmp("a_busy",        bus_a.busy,        m0.offer || m0.await_d || (m0.hold != 0));
        cmp("a_kbd_ready",   bus_a.kbd_ready,   !m0.kf);
        cmp("a_mouse_ready", bus_a.mouse_ready, !m0.mf);
        cmp("z_tx_valid",    bus_z.tx_valid,    m1.offer);
        cmp("z_tx_data",     bus_z.tx_data,     m1.pkt);
        cmp("z_busy",        bus_z.busy,        m1.offer || m1.await_d || (m1.hold != 0));
        cmp("z_kbd_ready",   bus_z.kbd_ready,   !m1.kf);
        cmp("z_mouse_ready", bus_z.mouse_ready, !m1.mf);
        case (done_mode)
            1: s_done = m0.await_d;
            2: s_done = m0.await_d ? ($urandom % 3 == 0) : ($urandom % 8 == 0);
            default: ;
        endcase
        reset_n = s_rst_n;
        bus_a.power_on_req = s_pwr; bus_z.power_on_req = s_pwr;
        bus_a.kbd_valid = s_kv;     bus_z.kbd_valid = s_kv;
        bus_a.kbd_data = s_kd;      bus_z.kbd_data = s_kd;
        bus_a.mouse_valid = s_mv;   bus_z.mouse_valid = s_mv;
        bus_a.mouse_data = s_md;    bus_z.mouse_data = s_md;
        bus_a.tx_ready = s_rdy;     bus_z.tx_ready = s_rdy;
        bus_a.tx_done = s_done;     bus_z.tx_done = s_done;
        if (bus_a.tx_valid && s_rdy && s_rst_n) begin
            log_d.push_back(bus_a.tx_data);
            log_c.push_back(cyc);
        end
        if (!s_rst_n) begin
            m0 = '0;
            m1 = '0;
        end else begin
            m0 = mdl_step(m0, c_gap_a, s_pwr, s_kv, s_kd, s_mv, s_md, s_rdy, s_done);
            m1 = mdl_step(m1, c_gap_z, s_pwr, s_kv, s_kd, s_mv, s_md, s_rdy, s_done);
        end
    endtask

    task automatic wait_quiet(input string nm);
        int k = 0;
        while ((bus_a.busy || m0.kf || m0.mf || m0.pwr) && k < 400) begin
            tick();
            k++;
        end
        cmp(nm, bus_a.busy, 1'b0);
    endtask

    task automatic wait_valid_a(input string nm);
        int k = 0;
        while (!bus_a.tx_valid && k < 20) begin
            tick();
            k++;
        end
        cmp(nm, bus_a.tx_valid, 1'b1);
    endtask

    initial begin
        int cap, first_v, n0;
        reset_n = 1'b0;
        bus_a.power_on_req = 1'b0; bus_z.power_on_req = 1'b0;
        bus_a.kbd_valid = 1'b0;    bus_z.kbd_valid = 1'b0;
        bus_a.kbd_data = '0;       bus_z.kbd_data = '0;
        bus_a.mouse_valid = 1'b0;  bus_z.mouse_valid = 1'b0;
        bus_a.mouse_data = '0;     bus_z.mouse_data = '0;
        bus_a.tx_ready = 1'b0;     bus_z.tx_ready = 1'b0;
        bus_a.tx_done = 1'b0;      bus_z.tx_done = 1'b0;

        repeat (3) tick();
        cmp("rst_tx_valid", bus_a.tx_valid, 1'b0);
        cmp("rst_tx_data", bus_a.tx_data, 40'h0);
        cmp("rst_busy", bus_a.busy, 1'b0);
        cmp("rst_kbd_ready", bus_a.kbd_ready, 1'b1);
        cmp("rst_mouse_ready", bus_a.mouse_ready, 1'b1);
        s_rst_n = 1'b1;
        s_rdy = 1'b1;
        done_mode = 1;
        tick();

        // Single keyboard packet: latency and busy span
        s_kv = 1'b1; s_kd = 16'h1234;
        tick();
        cap = cyc;
        s_kv = 1'b0;
        wait_valid_a("kbd_valid_seen");
        first_v = cyc;
        cmp("kbd_latency", 64'(first_v - cap), 64'd2);
        cmp("kbd_pkt", bus_a.tx_data, 40'hC610001234);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!bus_a.busy) break;
        end
        cmp("kbd_busy_span", 64'(cyc - first_v), 64'(c_gap_a + 2));

        // Simultaneous power-on, keyboard and mouse
        wait_quiet("quiet1");
        log_d.delete(); log_c.delete();
        s_pwr = 1'b1; s_kv = 1'b1; s_kd = 16'h0011; s_mv = 1'b1; s_md = 16'h0022;
        tick();
        s_pwr = 1'b0; s_kv = 1'b0; s_mv = 1'b0;
        for (int i = 0; i < 200 && log_d.size() < 3; i++) tick();
        cmp("trio_count", 64'(log_d.size()), 64'd3);
        if (log_d.size() == 3) begin
            cmp("trio_pkt0", log_d[0], 40'hC671000000);
            cmp("trio_pkt1", log_d[1], 40'hC610000011);
            cmp("trio_pkt2", log_d[2], 40'hC601000022);
            cmp("trio_gap01", (log_c[1] - log_c[0]) >= c_gap_a + 2, 1'b1);
            cmp("trio_gap12", (log_c[2] - log_c[1]) >= c_gap_a + 2, 1'b1);
        end

        // Back-pressure: held SEND, stray done ignored, single transfer
        wait_quiet("quiet2");
        s_rdy = 1'b0;
        s_kv = 1'b1; s_kd = 16'h0ABC;
        tick();
        s_kv = 1'b0;
        wait_valid_a("bp_valid_seen");
        done_mode = 0;
        s_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            cmp("bp_hold_valid", bus_a.tx_valid, 1'b1);
            cmp("bp_hold_data", bus_a.tx_data, 40'hC610000ABC);
        end
        s_done = 1'b0;
        n0 = log_d.size();
        s_rdy = 1'b1;
        repeat (3) tick();
        cmp("bp_one_xfer", 64'(log_d.size() - n0), 64'd1);
        cmp("bp_wait_valid", bus_a.tx_valid, 1'b0);
        cmp("bp_wait_busy", bus_a.busy, 1'b1);
        done_mode = 1;

        // Both sources continuously valid
        wait_quiet("quiet3");
        n0 = log_d.size();
        s_kv = 1'b1; s_mv = 1'b1;
        for (int i = 0; i < 160; i++) begin
            s_kd = 16'($urandom); s_md = 16'($urandom);
            tick();
        end
        s_kv = 1'b0; s_mv = 1'b0;
        cmp("both_enough", log_d.size() >= n0 + 4, 1'b1);
        for (int i = n0 + 1; i < log_d.size(); i++) begin
`ifdef OP_SCHED_RR_EN
            cmp("both_alternate", log_d[i][31:24] != log_d[i-1][31:24], 1'b1);
`else
            cmp("both_kbd_only", log_d[i][31:24], 8'h10);
`endif
        end

        // Reset while waiting for done with keyboard buffer full
        wait_quiet("quiet4");
        done_mode = 0; s_done = 1'b0;
        s_kv = 1'b1; s_kd = 16'h5555;
        tick();
        s_kv = 1'b0;
        wait_valid_a("wd_valid_seen");
        tick();
        s_kv = 1'b1; s_kd = 16'h6666;
        tick();
        s_kv = 1'b0;
        repeat (2) tick();
        cmp("wd_busy", bus_a.busy, 1'b1);
        cmp("wd_kbd_full", bus_a.kbd_ready, 1'b0);
        s_rst_n = 1'b0;
        tick();
        s_rst_n = 1'b1;
        tick();
        cmp("wdrst_tx_valid", bus_a.tx_valid, 1'b0);
        cmp("wdrst_busy", bus_a.busy, 1'b0);
        cmp("wdrst_kbd_ready", bus_a.kbd_ready, 1'b1);
        n0 = log_d.size();
        done_mode = 1;
        repeat (40) tick();
        cmp("wdrst_no_pkt", 64'(log_d.size() - n0), 64'd0);

        // Zero-gap instance: done -> IDLE -> pending mouse offered
        done_mode = 0; s_done = 1'b0;
        s_kv = 1'b1; s_kd = 16'h0001;
        tick();
        s_kv = 1'b0;
        for (int i = 0; i < 20 && !bus_z.tx_valid; i++) tick();
        cmp("z_first_valid", bus_z.tx_valid, 1'b1);
        tick();
        s_mv = 1'b1; s_md = 16'h00FF;
        tick();
        s_mv = 1'b0;
        tick();
        s_done = 1'b1;
        tick();
        s_done = 1'b0;
        tick();
        cmp("z_idle_after_done", bus_z.busy, 1'b0);
        tick();
        cmp("z_mouse_valid", bus_z.tx_valid, 1'b1);
        cmp("z_mouse_pkt", bus_z.tx_data, 40'hC6010000FF);

        // Randomized traffic, stray done pulses and occasional reset
        done_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            s_pwr   = ($urandom % 16 == 0);
            s_kv    = $urandom % 2;
            s_kd    = 16'($urandom);
            s_mv    = $urandom % 2;
            s_md    = 16'($urandom);
            s_rdy   = ($urandom % 4 != 0);
            s_rst_n = ($urandom % 700 != 0);
            tick();
        end
        s_pwr = 1'b0; s_kv = 1'b0; s_mv = 1'b0; s_rdy = 1'b1; s_rst_n = 1'b1;
        done_mode = 1;
        wait_quiet("final_quiet");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/op_scheduler.md
OP_SCHEDULER -- requirements
Module: op_scheduler

Interface
REQ-001 Parameter: GAP_CYCLES, 16, idle clock cycles enforced after each completed packet (0 = no gap).
REQ-002 Port: clk  input  1  single system clock; all logic on rising edge.
REQ-003 Port: reset_n  input  1  synchronous, active-low reset.
REQ-004 Port: power_on_req  input  1  single-cycle request for a power-on packet.
REQ-005 Port: kbd_valid / kbd_ready  input / output  1 / 1  keyboard source handshake.
REQ-006 Port: kbd_data  input  16  keyboard payload bytes.
REQ-007 Port: mouse_valid / mouse_ready  input / output  1 / 1  mouse source handshake.
REQ-008 Port: mouse_data  input  16  mouse payload bytes.
REQ-009 Port: tx_data  output  40  packet to serial transmitter.
REQ-010 Port: tx_valid / tx_ready  output / input  1 / 1  transmitter handshake; transfer when both high.
REQ-011 Port: tx_done  input  1  one-cycle pulse; transmitter finished shifting the current packet.
REQ-012 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-013 Each source SHALL have a one-entry holding buffer; ready = buffer empty; capture on valid && ready.
REQ-014 power_on_req SHALL set a sticky pending flag; pulses while pending SHALL merge into one packet.
REQ-015 FSM states SHALL be IDLE, SEND, WAIT_DONE, GAP.
REQ-016 IDLE: if any request pending, select winner, register tx_data, clear winner's buffer/flag, go SEND next cycle; otherwise stay.
REQ-017 Priority SHALL be power-on above keyboard/mouse; keyboard vs mouse per REQ-027.
REQ-018 Packet formats: power-on 0xC671000000; keyboard {0xC6,0x10,0x00,kbd_data}; mouse {0xC6,0x01,0x00,mouse_data}.
REQ-019 SEND: tx_valid = 1; tx_data SHALL stay stable until tx_ready; on tx_valid && tx_ready go WAIT_DONE.
REQ-020 WAIT_DONE: tx_valid = 0; on tx_done go GAP (or IDLE when GAP_CYCLES = 0); tx_done in any other state SHALL be ignored.
REQ-021 GAP: counter loads GAP_CYCLES-1 on entry, decrements each cycle, goes IDLE the cycle after reaching 0; exactly GAP_CYCLES cycles spent in GAP.
REQ-022 Latency: source capture at cycle N -> tx_valid high at N+2 when FSM idle and no higher-priority request.
REQ-023 Sources SHALL continue to be captured in every state; at most one pending entry per source.
REQ-024 Simultaneous power_on_req, kbd and mouse captures in one cycle SHALL all be retained and served in priority order.

Reset
REQ-025 On reset_n low at a clock edge: FSM = IDLE, buffers empty, power-on flag clear, gap counter 0, round-robin pointer = keyboard.
REQ-026 Reset values: tx_valid 0, tx_data 0, busy 0, kbd_ready 1 and mouse_ready 1 from first cycle after reset; reset mid-packet discards all pending data.

Configuration
REQ-027 Macro OP_SCHED_RR_EN defined: keyboard/mouse SHALL alternate when both pending, pointer toggling after each keyboard or mouse packet granted; undefined: keyboard SHALL always win over mouse and no pointer register exists.

Structure
REQ-028 Shared package/include SHALL hold packet constants (0xC6 header, 0x10 keyboard, 0x01 mouse, 0xC671000000 power-on) and FSM state encodings.
REQ-029 One sub-module, op_src_buffer (one-entry valid/ready holding register with clear input), SHALL be instantiated for keyboard and mouse.

Verification
REQ-030 kbd_data=0x1234 accepted at cycle N, tx_ready=1 -> tx_valid at N+2, tx_data=0xC610001234, busy high until GAP ends.
REQ-031 power_on_req, kbd 0x0011, mouse 0x0022 same cycle -> packets in order 0xC671000000, 0xC610000011, 0xC601000022, each separated by >= GAP_CYCLES idle cycles.
REQ-032 tx_ready held low 5 cycles during SEND -> tx_valid and tx_data stable all 5 cycles; single transfer; WAIT_DONE until tx_done.
REQ-033 Keyboard and mouse both continuously valid, OP_SCHED_RR_EN defined -> strict alternation kbd, mouse, kbd...; undefined -> keyboard only while keyboard valid.
REQ-034 reset_n low in WAIT_DONE with kbd buffer full -> next cycle tx_valid 0, busy 0, kbd_ready 1; no packet emitted afterwards without new input.
REQ-035 GAP_CYCLES=0 and tx_done -> IDLE next cycle; pending mouse 0x00FF produces tx_valid one cycle later.
